combo_dialer: RTL and testbench
===============================

COMBO_DIALER -- requirements
Module: combo_dialer

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 4, number of WAIT cycles to sample open before declaring failure (legal range 1..15).
REQ-002 SHALL have ports: clk  input  1  single clock, all state on posedge clk.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: start  input  1  request to dial; sampled only while ready=1.
REQ-005 SHALL have ports: part  input  14x3 (part[2:0])  decimal combination parts, binary-coded, legal 0..9999; captured on accepted start.
REQ-006 SHALL have ports: open  input  1  lock status returned from the lock under drive.
REQ-007 SHALL have ports: digits  output  10x4 (digits[3:0])  one-hot digit lanes to lock; lane 0 = ones, lane 3 = thousands.
REQ-008 SHALL have ports: ready  output  1  high only in IDLE.
REQ-009 SHALL have ports: done  output  1  one-cycle pulse at end of an attempt.
REQ-010 SHALL have ports: success  output  1  valid with done; 1 = open observed within TIMEOUT.
REQ-011 SHALL have ports: err  output  1  one-cycle pulse when a start is rejected for an out-of-range part.

Function
REQ-012 SHALL implement FSM states IDLE, CONVERT, SEND2, SEND1, SEND0, WAIT, FINISH.
REQ-013 IDLE: start=1 with all part<=9999 -> capture parts, go CONVERT next cycle; start with any part>9999 -> err pulse next cycle, stay IDLE, nothing dialed.
REQ-014 CONVERT SHALL run three parallel serial binary-to-BCD conversions (shift-add-3), exactly 14 cycles, then go SEND2.
REQ-015 SEND2, SEND1, SEND0 SHALL each last exactly one cycle, driving digits[j] = one-hot(decimal digit j of part[2], part[1], part[0] respectively), order part[2] first.
REQ-016 In every state other than SEND*, digits SHALL be all lanes = 10'b1 (value 0); digits SHALL be one-hot on every lane on every cycle, including during reset.
REQ-017 digits SHALL be a registered output (no combinational path from inputs).
REQ-018 WAIT SHALL sample open on each of up to TIMEOUT cycles, the first sample being the cycle after SEND0; open=1 -> FINISH with success=1; TIMEOUT samples with open=0 -> FINISH with success=0.
REQ-019 FINISH SHALL last one cycle with done=1 and success per REQ-018, then return to IDLE; success SHALL be 0 whenever done=0.
REQ-020 start outside IDLE SHALL be ignored (not queued); part changes after capture SHALL have no effect.
REQ-021 open outside WAIT SHALL be ignored.
REQ-022 Start to done latency SHALL be 1+14+3+k+1 cycles, where k = WAIT cycles used (1..TIMEOUT).

Reset
REQ-023 On rst=1: state=IDLE, digits all lanes 10'b1, ready=1, done=0, success=0, err=0, captured parts and BCD registers cleared.
REQ-024 rst asserted mid-attempt (any state) SHALL abort immediately, with no done pulse for the aborted attempt.

Structure
REQ-025 Shared package combo_pkg SHALL hold the one-hot digit constants C0..C9, a 10-bit digit typedef, the FSM state enum, and MAX_PART=9999.
REQ-026 SHALL instantiate three copies of sub-module bin2bcd14 (start, 14-bit bin in, 4x4-bit BCD out, done after 14 cycles).
REQ-027 The lock-side combo packing SHALL not be duplicated here.

Verification
REQ-028 part={2730,0,2730}, start -> SEND2/SEND1/SEND0 digits = {C2,C7,C3,C0},{C0,C0,C0,C0},{C2,C7,C3,C0}; with a real combination_lock attached, done=1, success=1 at cycle 20 after start.
REQ-029 part={1234,5678,9}, open tied 0 -> digit lanes {C1,C2,C3,C4},{C5,C6,C7,C8},{C0,C0,C0,C9}; done at start+18+TIMEOUT+1, success=0.
REQ-030 part={10000,0,0}, start -> err pulse next cycle, ready stays 1, digits stay all C0, no done.
REQ-031 Boundary: part={9999,0,9999} -> all lanes C9 in SEND2 and SEND0, all C0 in SEND1; a second start pulsed during CONVERT is ignored (exactly one done).
REQ-032 rst asserted during SEND1 -> next cycle digits all C0, ready=1, no done; a fresh start afterwards completes normally.
REQ-033 Bench SHALL assert every cycle: $onehot on each digits lane, done implies $past(state)=WAIT, success implies done.

Source files
------------

// File: rtl/combo_pkg.sv
// Shared types and constants for the combination dialer.
// One-hot digit encodings, FSM states and BCD helpers.
package combo_pkg;

    localparam int PART_W      = 14;
    localparam int NUM_PARTS   = 3;
    localparam int NUM_LANES   = 4;
    localparam int CONV_CYCLES = 14;

    localparam logic [PART_W-1:0] MAX_PART = 14'd9999;

    typedef logic [9:0] digit_t;

    localparam digit_t C0 = 10'b00_0000_0001;
    localparam digit_t C1 = 10'b00_0000_0010;
    localparam digit_t C2 = 10'b00_0000_0100;
    localparam digit_t C3 = 10'b00_0000_1000;
    localparam digit_t C4 = 10'b00_0001_0000;
    localparam digit_t C5 = 10'b00_0010_0000;
    localparam digit_t C6 = 10'b00_0100_0000;
    localparam digit_t C7 = 10'b00_1000_0000;
    localparam digit_t C8 = 10'b01_0000_0000;
    localparam digit_t C9 = 10'b10_0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SEND2,
        SEND1,
        SEND0,
        WAIT,
        FINISH
    } state_t;

    function automatic digit_t bcd_to_onehot(input logic [3:0] d);
        digit_t r;
        r = C0;
        if (d <= 4'd9) begin
            r = 10'd1 << d;
        end
        return r;
    endfunction

    // Shift-add-3 correction applied to each nibble before a shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/combo_dialer_bin2bcd14.sv
// Serial 14-bit binary to 4-digit BCD converter (shift-add-3).
// The first shift happens on the load edge, so done pulses 14 cycles later.
module bin2bcd14
    import combo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [13:0]      bin,
    output logic [3:0][3:0]  bcd,
    output logic             done
);

    logic [13:0] sr_q, sr_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] adj;

    always_comb begin
        sr_d   = sr_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        adj    = bcd_adjust(bcd_q);
        if (start) begin
            bcd_d  = {15'd0, bin[13]};
            sr_d   = {bin[12:0], 1'b0};
            cnt_d  = 4'd1;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {adj[14:0], sr_q[13]};
            sr_d  = {sr_q[12:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(CONV_CYCLES - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/combo_dialer.sv
// Dials a three-part decimal combination onto one-hot digit lanes
// and waits a bounded number of cycles for the lock to report open.
module combo_dialer
    import combo_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0][13:0]  part,
    input  logic              open,
    output logic [3:0][9:0]   digits,
    output logic              ready,
    output logic              done,
    output logic              success,
    output logic              err
);

    localparam digit_t [3:0] ALL_C0 = {C0, C0, C0, C0};

    state_t          state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [3:0][9:0] digits_q, digits_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            success_q, success_d;
    logic            err_q, err_d;

    logic [2:0][3:0][3:0] bcd;
    logic [2:0]           cdone;
    logic                 in_range;
    logic                 conv_go;

    always_comb begin
        in_range = 1'b1;
        for (int i = 0; i < NUM_PARTS; i++) begin
            if (part[i] > MAX_PART) begin
                in_range = 1'b0;
            end
        end
    end

    assign conv_go = (state_q == IDLE) && start && in_range;

    // The converters' shift registers are the captured copy of part.
    for (genvar g = 0; g < NUM_PARTS; g++) begin : g_conv
        bin2bcd14 u_conv (
            .clk   (clk),
            .rst   (rst),
            .start (conv_go),
            .bin   (part[g]),
            .bcd   (bcd[g]),
            .done  (cdone[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        done_d    = 1'b0;
        success_d = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (in_range) begin
                        state_d = CONVERT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CONVERT: begin
                if (&cdone) begin
                    state_d = SEND2;
                end
            end
            SEND2: state_d = SEND1;
            SEND1: state_d = SEND0;
            SEND0: begin
                state_d = WAIT;
                wcnt_d  = '0;
            end
            WAIT: begin
                if (open) begin
                    state_d   = FINISH;
                    done_d    = 1'b1;
                    success_d = 1'b1;
                end else if (wcnt_q == 4'(TIMEOUT - 1)) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_comb begin
        digits_d = ALL_C0;
        for (int j = 0; j < NUM_LANES; j++) begin
            unique case (state_d)
                SEND2:   digits_d[j] = bcd_to_onehot(bcd[2][j]);
                SEND1:   digits_d[j] = bcd_to_onehot(bcd[1][j]);
                SEND0:   digits_d[j] = bcd_to_onehot(bcd[0][j]);
                default: digits_d[j] = C0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            digits_q  <= ALL_C0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            success_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            digits_q  <= digits_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            success_q <= success_d;
            err_q     <= err_d;
        end
    end

    assign digits  = digits_q;
    assign ready   = ready_q;
    assign done    = done_q;
    assign success = success_q;
    assign err     = err_q;

endmodule

// File: tb/tb_combo_dialer.sv
// Directed bench for combo_dialer with a small registered lock model.
// Cycle n counts clock edges after the edge that accepts start.
module tb_combo_dialer;
    import combo_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0][13:0] part;
    logic            open;
    logic [3:0][9:0] digits;
    logic            ready;
    logic            done;
    logic            success;
    logic            err;

    int n_chk  = 0;
    int n_fail = 0;
    int mode   = 0;

    logic [39:0] lk2 = '0;
    logic [39:0] lk1 = '0;
    logic [39:0] lk0 = '0;
    logic [39:0] h1_q = '0;
    logic [39:0] h2_q = '0;
    logic        lock_open = 1'b0;
    state_t      prev_st = IDLE;

    localparam logic [39:0] ALL0 = {C0, C0, C0, C0};
    localparam logic [39:0] ALL9 = {C9, C9, C9, C9};

    combo_dialer #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .part    (part),
        .open    (open),
        .digits  (digits),
        .ready   (ready),
        .done    (done),
        .success (success),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Lock opens one cycle after seeing part2, part1, part0 in a row.
    always @(posedge clk) begin
        h1_q      <= digits;
        h2_q      <= h1_q;
        lock_open <= (digits == lk0) && (h1_q == lk1) && (h2_q == lk2);
        prev_st   <= dut.state_q;
    end

    assign open = (mode == 1) ? lock_open : (mode == 2);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk("onehot_lane", 64'($onehot(digits[i])), 64'd1);
        end
        if (done) begin
            chk("done_after_wait", 64'(prev_st), 64'(WAIT));
        end
        if (success) begin
            chk("success_needs_done", 64'(done), 64'd1);
        end
    end

    task automatic dial(input logic [13:0] a2, input logic [13:0] a1,
                        input logic [13:0] a0, input int m,
                        input bit dbl, input bit exp_ok, input int exp_k,
                        input bit exp_succ, input logic [39:0] e2,
                        input logic [39:0] e1, input logic [39:0] e0);
        int dones;
        int lat;
        dones = 0;
        lat   = -1;
        mode  = m;
        lk2   = e2;
        lk1   = e1;
        lk0   = e0;
        @(posedge clk);
        #1;
        part[2] = a2;
        part[1] = a1;
        part[0] = a0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        part  = {14'd1111, 14'd2222, 14'd4444};
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("err_pulse", 64'(err), 64'(!exp_ok));
                chk("ready_after_start", 64'(ready), 64'(!exp_ok));
            end
            if (n == 2) chk("err_cleared", 64'(err), 64'd0);
            if (n == 10) begin
                chk("convert_digits", 64'(digits), 64'(ALL0));
            end
            if (dbl && n == 5) start = 1'b1;
            if (dbl && n == 6) start = 1'b0;
            if (exp_ok && n == 15) chk("send2", 64'(digits), 64'(e2));
            if (exp_ok && n == 16) chk("send1", 64'(digits), 64'(e1));
            if (exp_ok && n == 17) chk("send0", 64'(digits), 64'(e0));
            if (exp_ok && n == 18) chk("wait_digits", 64'(digits), 64'(ALL0));
            if (done) begin
                dones++;
                if (lat < 0) lat = n;
                chk("success", 64'(success), 64'(exp_succ));
            end
        end
        if (exp_ok) begin
            chk("done_cycle", 64'(lat), 64'(18 + exp_k));
            chk("done_count", 64'(dones), 64'd1);
        end else begin
            chk("no_done", 64'(dones), 64'd0);
        end
        chk("ready_end", 64'(ready), 64'd1);
    endtask

    initial begin
        int dones;
        rst   = 1'b1;
        start = 1'b0;
        part  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_success", 64'(success), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_digits", 64'(digits), 64'(ALL0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        dial(14'd2730, 14'd0, 14'd2730, 1, 1'b0, 1'b1, 1, 1'b1,
             {C2, C7, C3, C0}, ALL0, {C2, C7, C3, C0});
        dial(14'd1234, 14'd5678, 14'd9, 0, 1'b0, 1'b1, 4, 1'b0,
             {C1, C2, C3, C4}, {C5, C6, C7, C8}, {C0, C0, C0, C9});
        dial(14'd10000, 14'd0, 14'd0, 2, 1'b0, 1'b0, 0, 1'b0,
             ALL0, ALL0, ALL0);
        dial(14'd0, 14'd0, 14'd16383, 2, 1'b0, 1'b0, 0, 1'b0,
             ALL0, ALL0, ALL0);
        dial(14'd9999, 14'd0, 14'd9999, 1, 1'b1, 1'b1, 1, 1'b1,
             ALL9, ALL0, ALL9);
        dial(14'd0, 14'd42, 14'd9, 2, 1'b0, 1'b1, 1, 1'b1,
             ALL0, {C0, C0, C4, C2}, {C0, C0, C0, C9});

        // Abort in SEND1 with an asynchronous reset.
        mode = 0;
        @(posedge clk);
        #1;
        part  = {14'd1234, 14'd5678, 14'd9};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 16; n++) @(negedge clk);
        chk("pre_abort_send1", 64'(digits), 64'({C5, C6, C7, C8}));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_digits", 64'(digits), 64'(ALL0));
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        dones = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);

        dial(14'd2730, 14'd0, 14'd2730, 1, 1'b0, 1'b1, 1, 1'b1,
             {C2, C7, C3, C0}, ALL0, {C2, C7, C3, C0});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
